// File: rtl/tmds_pkg.sv
// Shared TMDS definitions for the DVI transmit path.
//   TMDS_CTRL_xx : 10-bit control tokens, indexed by c1c0.
//   IDLE_LO/HI   : the c1c0=00 token split into the two 15-bit halves
//                  the gearbox emits (low 5 bits of each channel first).
//   gb_state_e   : gearbox sequencing states.
package tmds_pkg;

  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

  // {ch2,ch1,ch0} slices of TMDS_CTRL_00: 15'h5294 and 15'h6B5A.
  localparam logic [14:0] IDLE_LO = {3{TMDS_CTRL_00[4:0]}};
  localparam logic [14:0] IDLE_HI = {3{TMDS_CTRL_00[9:5]}};

  typedef enum logic {
    GB_PREFILL = 1'b0,
    GB_RUN     = 1'b1
  } gb_state_e;

endpackage

// File: rtl/tmds_gearbox_30to15_ram.sv
// Word store for the 30-to-15 gearbox.
//   pclkx2 : write clock
//   we     : write enable, wdata stored at waddr on the rising edge
//   raddr  : read address; rdata follows it combinationally
module tmds_gearbox_30to15_ram #(
  parameter int DEPTH = 4
) (
  input  logic                       pclkx2,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [29:0]                wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [29:0]                rdata
);

  logic [29:0] mem_q [DEPTH];

  // Storage is not reset; the pointers/level in the top decide what is valid.
  always_ff @(posedge pclkx2) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/tmds_gearbox_30to15.sv
// 30-to-15-bit TMDS gearbox, pclkx2 domain.
// Takes one packed 30-bit encoder word per pixel clock and emits one 15-bit
// serializer slice per pclkx2 cycle, first half first. When starved it emits
// the c1c0=00 control token so the serializers keep a DC-balanced stream.
//   pclkx2     : gearbox clock (2x pixel clock)
//   rstin      : asynchronous active-high reset
//   din        : {r[4:0],g[4:0],b[4:0],r[9:5],g[9:5],b[9:5]}
//   din_valid  : write strobe
//   clr_flags  : synchronous clear of underflow/overflow
//   dout       : {ch2,ch1,ch0} 5-bit slices
//   dout_first : dout holds a first half
//   running    : streaming real data
//   level      : stored word count
//   underflow  : sticky, word boundary found buffer empty while running
//   overflow   : sticky, a write was dropped on a full buffer
//
// state      | meaning
// GB_PREFILL | emitting idle token, waiting for PREFILL words
// GB_RUN     | emitting buffered words, one half per cycle
module tmds_gearbox_30to15
  import tmds_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int PREFILL = 2
) (
  input  logic                     pclkx2,
  input  logic                     rstin,
  input  logic [29:0]              din,
  input  logic                     din_valid,
  input  logic                     clr_flags,
  output logic [14:0]              dout,
  output logic                     dout_first,
  output logic                     running,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underflow,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  gb_state_e     state_q, state_d;
  logic          phase_q, phase_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [14:0]   half_q, half_d;
  logic [14:0]   dout_q, dout_d;
  logic          first_q, first_d;
  logic          running_q, running_d;
  logic          underflow_q, underflow_d;
  logic          overflow_q, overflow_d;

  logic          pop;
  logic          wr_en;
  logic          uf_set;
  logic          of_set;
  logic [29:0]   rd_word;

  tmds_gearbox_30to15_ram #(.DEPTH(DEPTH)) u_ram (
    .pclkx2 (pclkx2),
    .we     (wr_en),
    .waddr  (wr_ptr_q),
    .wdata  (din),
    .raddr  (rd_ptr_q),
    .rdata  (rd_word)
  );

  always_comb begin
    state_d = state_q;
    phase_d = ~phase_q;
    first_d = ~phase_q;
    dout_d  = dout_q;
    half_d  = half_q;
    pop     = 1'b0;
    uf_set  = 1'b0;

    // phase_q==0 marks a word boundary; phase_q==1 completes the word.
    case (state_q)
      GB_PREFILL: begin
        if (!phase_q) begin
          if (level_q >= LW'(PREFILL)) begin
            state_d = GB_RUN;
            pop     = 1'b1;
            dout_d  = rd_word[29:15];
            half_d  = rd_word[14:0];
          end else begin
            dout_d = IDLE_LO;
          end
        end else begin
          dout_d = IDLE_HI;
        end
      end
      GB_RUN: begin
        if (!phase_q) begin
          if (level_q != '0) begin
            pop    = 1'b1;
            dout_d = rd_word[29:15];
            half_d = rd_word[14:0];
          end else begin
            uf_set  = 1'b1;
            dout_d  = IDLE_LO;
            state_d = GB_PREFILL;
          end
        end else begin
          dout_d = half_q;
        end
      end
      default: begin
        state_d = GB_PREFILL;
        dout_d  = IDLE_LO;
      end
    endcase

    // A pop in the same cycle frees the slot the write lands in.
    wr_en  = din_valid && ((level_q != LW'(DEPTH)) || pop);
    of_set = din_valid && (level_q == LW'(DEPTH)) && !pop;

    wr_ptr_d = wr_ptr_q + AW'(wr_en);
    rd_ptr_d = rd_ptr_q + AW'(pop);

    case ({wr_en, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    running_d   = (state_d == GB_RUN);
    underflow_d = uf_set | (underflow_q & ~clr_flags);
    overflow_d  = of_set | (overflow_q & ~clr_flags);
  end

  always_ff @(posedge pclkx2 or posedge rstin) begin
    if (rstin) begin
      state_q     <= GB_PREFILL;
      phase_q     <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      half_q      <= IDLE_HI;
      dout_q      <= IDLE_LO;
      first_q     <= 1'b1;
      running_q   <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      half_q      <= half_d;
      dout_q      <= dout_d;
      first_q     <= first_d;
      running_q   <= running_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  assign dout       = dout_q;
  assign dout_first = first_q;
  assign running    = running_q;
  assign level      = level_q;
  assign underflow  = underflow_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_tmds_gearbox_30to15.sv
// Directed bench for tmds_gearbox_30to15 (DEPTH=4, PREFILL=2).
// Edge index e counts rising edges since reset release; odd e are word
// boundaries. Expected sequences below are worked out by hand.
module tb_tmds_gearbox_30to15;

  logic        pclkx2 = 1'b0;
  logic        rstin  = 1'b1;
  logic [29:0] din    = '0;
  logic        din_valid = 1'b0;
  logic        clr_flags = 1'b0;
  logic [14:0] dout;
  logic        dout_first;
  logic        running;
  logic [2:0]  level;
  logic        underflow;
  logic        overflow;

  int total  = 0;
  int passed = 0;
  int e      = 0;

  tmds_gearbox_30to15 #(.DEPTH(4), .PREFILL(2)) dut (
    .pclkx2     (pclkx2),
    .rstin      (rstin),
    .din        (din),
    .din_valid  (din_valid),
    .clr_flags  (clr_flags),
    .dout       (dout),
    .dout_first (dout_first),
    .running    (running),
    .level      (level),
    .underflow  (underflow),
    .overflow   (overflow)
  );

  always #5 pclkx2 = ~pclkx2;

  function automatic logic [29:0] w(input int j);
    logic [14:0] hi, lo;
    hi = 15'h1000 + 15'(j);
    lo = 15'h0100 + 15'(j);
    return {hi, lo};
  endfunction

  task automatic step(input logic v, input logic [29:0] d, input logic clr);
    din_valid = v;
    din       = d;
    clr_flags = clr;
    @(posedge pclkx2);
    #1;
    e++;
    din_valid = 1'b0;
    clr_flags = 1'b0;
  endtask

  task automatic do_reset();
    din_valid = 1'b0;
    clr_flags = 1'b0;
    rstin = 1'b1;
    @(posedge pclkx2);
    @(negedge pclkx2);
    rstin = 1'b0;
    e = 0;
  endtask

  task automatic test_reset();
    rstin = 1'b1;
    @(posedge pclkx2);
    #1;
    total++; if (dout !== 15'h5294) $display("FAIL rst_dout got %h exp 5294", dout); else passed++;
    total++; if (dout_first !== 1'b1) $display("FAIL rst_first got %b exp 1", dout_first); else passed++;
    total++; if (running !== 1'b0) $display("FAIL rst_running got %b exp 0", running); else passed++;
    total++; if (level !== 3'd0) $display("FAIL rst_level got %0d exp 0", level); else passed++;
    total++; if ({underflow, overflow} !== 2'b00) $display("FAIL rst_flags got %b exp 00", {underflow, overflow}); else passed++;
    @(negedge pclkx2);
    rstin = 1'b0;
    e = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, '0, 1'b0);
      total++;
      if (dout !== ((e % 2 == 1) ? 15'h5294 : 15'h6B5A))
        $display("FAIL idle_dout e=%0d got %h", e, dout);
      else passed++;
      total++; if (dout_first !== 1'(e % 2)) $display("FAIL idle_first e=%0d got %b", e, dout_first); else passed++;
      total++;
      if ({running, underflow, overflow, level} !== 6'b0)
        $display("FAIL idle_status e=%0d got run=%b uf=%b of=%b lvl=%0d exp all 0", e, running, underflow, overflow, level);
      else passed++;
    end
  endtask

  task automatic test_stream();
    logic [14:0] dout_tab [16] = '{15'h5294, 15'h6B5A, 15'h5294, 15'h6B5A,
                                   15'h1000, 15'h0100, 15'h1001, 15'h0101,
                                   15'h1002, 15'h0102, 15'h1003, 15'h0103,
                                   15'h1004, 15'h0104, 15'h1005, 15'h0105};
    int lvl_tab [16] = '{0, 1, 1, 2, 1, 2, 1, 2, 1, 2, 1, 2, 1, 1, 0, 0};
    do_reset();
    // W_j written at edge 2j+2, last one W_5 at edge 12.
    for (int i = 0; i < 16; i++) begin
      step(((i + 1) % 2 == 0) && (i + 1 <= 12), w((i - 1) / 2), 1'b0);
      total++; if (dout !== dout_tab[i]) $display("FAIL stream_dout e=%0d got %h exp %h", e, dout, dout_tab[i]); else passed++;
      total++; if (dout_first !== 1'(e % 2)) $display("FAIL stream_first e=%0d got %b", e, dout_first); else passed++;
      total++; if (running !== (e >= 5)) $display("FAIL stream_running e=%0d got %b", e, running); else passed++;
      total++; if (level !== 3'(lvl_tab[i])) $display("FAIL stream_level e=%0d got %0d exp %0d", e, level, lvl_tab[i]); else passed++;
      total++; if ({underflow, overflow} !== 2'b00) $display("FAIL stream_flags e=%0d got %b exp 00", e, {underflow, overflow}); else passed++;
    end
  endtask

  task automatic test_underflow_restart();
    logic [14:0] dout_tab [10] = '{15'h5294, 15'h6B5A, 15'h5294, 15'h6B5A, 15'h5294,
                                   15'h6B5A, 15'h1006, 15'h0106, 15'h1007, 15'h0107};
    int lvl_tab [10] = '{0, 0, 0, 1, 1, 2, 1, 2, 1, 2};
    // Edges 17..26; restart writes W6..W9 at edges 20,22,24,26.
    for (int i = 0; i < 10; i++) begin
      step(((e + 1) % 2 == 0) && (e + 1 >= 20), w((e + 1 - 8) / 2), 1'b0);
      total++; if (dout !== dout_tab[i]) $display("FAIL uf_dout e=%0d got %h exp %h", e, dout, dout_tab[i]); else passed++;
      total++; if (dout_first !== 1'(e % 2)) $display("FAIL uf_first e=%0d got %b", e, dout_first); else passed++;
      total++; if (running !== (e >= 23)) $display("FAIL uf_running e=%0d got %b", e, running); else passed++;
      total++; if (level !== 3'(lvl_tab[i])) $display("FAIL uf_level e=%0d got %0d exp %0d", e, level, lvl_tab[i]); else passed++;
      total++; if (underflow !== 1'b1) $display("FAIL uf_sticky e=%0d got %b exp 1", e, underflow); else passed++;
      total++; if (overflow !== 1'b0) $display("FAIL uf_no_of e=%0d got %b exp 0", e, overflow); else passed++;
    end
  endtask

  task automatic test_clr_alone();
    step(1'b0, '0, 1'b1);
    total++; if ({underflow, overflow} !== 2'b00) $display("FAIL clr_alone got %b exp 00", {underflow, overflow}); else passed++;
    total++; if (dout !== 15'h1008) $display("FAIL clr_alone_dout got %h exp 1008", dout); else passed++;
  endtask

  task automatic test_overflow();
    logic [14:0] dout_tab [8] = '{15'h5294, 15'h6B5A, 15'h1000, 15'h0100,
                                  15'h1001, 15'h0101, 15'h1002, 15'h0102};
    int lvl_tab [8] = '{1, 2, 2, 3, 3, 4, 4, 4};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, w(i), 1'b0);
      total++; if (dout !== dout_tab[i]) $display("FAIL of_dout e=%0d got %h exp %h", e, dout, dout_tab[i]); else passed++;
      total++; if (level !== 3'(lvl_tab[i])) $display("FAIL of_level e=%0d got %0d exp %0d", e, level, lvl_tab[i]); else passed++;
      total++; if (overflow !== (e == 8)) $display("FAIL of_flag e=%0d got %b", e, overflow); else passed++;
    end
  endtask

  task automatic test_clr_vs_set();
    // Edge 9: write accepted alongside pop, clear alone drops the flag.
    step(1'b1, w(8), 1'b1);
    total++; if (overflow !== 1'b0) $display("FAIL clr_of got %b exp 0", overflow); else passed++;
    total++; if (dout !== 15'h1003) $display("FAIL clr_of_dout got %h exp 1003", dout); else passed++;
    // Edge 10: dropped write and clear together, set wins.
    step(1'b1, w(9), 1'b1);
    total++; if (overflow !== 1'b1) $display("FAIL set_wins got %b exp 1", overflow); else passed++;
    total++; if (level !== 3'd4) $display("FAIL set_wins_level got %0d exp 4", level); else passed++;
    step(1'b1, w(10), 1'b0);
    total++; if (dout !== 15'h1004) $display("FAIL of_e11_dout got %h exp 1004", dout); else passed++;
    step(1'b1, w(11), 1'b0);
    total++; if (dout !== 15'h0104) $display("FAIL of_e12_dout got %h exp 0104", dout); else passed++;
  endtask

  task automatic test_drain();
    // Accepted but not yet emitted: W5, W6, W8, W10 (W7, W9, W11 dropped).
    logic [14:0] dout_tab [9] = '{15'h1005, 15'h0105, 15'h1006, 15'h0106, 15'h1008,
                                  15'h0108, 15'h100A, 15'h010A, 15'h5294};
    int lvl_tab [9] = '{3, 3, 2, 2, 1, 1, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      step(1'b0, '0, 1'b0);
      total++; if (dout !== dout_tab[i]) $display("FAIL drain_dout e=%0d got %h exp %h", e, dout, dout_tab[i]); else passed++;
      total++; if (level !== 3'(lvl_tab[i])) $display("FAIL drain_level e=%0d got %0d exp %0d", e, level, lvl_tab[i]); else passed++;
      total++; if (underflow !== (e == 21)) $display("FAIL drain_uf e=%0d got %b", e, underflow); else passed++;
    end
    total++; if (running !== 1'b0) $display("FAIL drain_running got %b exp 0", running); else passed++;
  endtask

  task automatic test_reset_midword();
    do_reset();
    for (int i = 0; i < 5; i++) step((e + 1) % 2 == 0, w((e + 1) / 2 - 1), 1'b0);
    total++; if (dout !== 15'h1000) $display("FAIL mid_pre got %h exp 1000", dout); else passed++;
    #2;
    rstin = 1'b1;
    #1;
    total++; if (dout !== 15'h5294) $display("FAIL mid_rst_dout got %h exp 5294", dout); else passed++;
    total++; if (dout_first !== 1'b1) $display("FAIL mid_rst_first got %b exp 1", dout_first); else passed++;
    total++; if (running !== 1'b0) $display("FAIL mid_rst_running got %b exp 0", running); else passed++;
    total++; if (level !== 3'd0) $display("FAIL mid_rst_level got %0d exp 0", level); else passed++;
    @(posedge pclkx2);
    #1;
    total++; if (dout !== 15'h5294) $display("FAIL mid_rst_hold got %h exp 5294", dout); else passed++;
    @(negedge pclkx2);
    rstin = 1'b0;
    e = 0;
    for (int i = 0; i < 6; i++) begin
      step((e + 1) % 2 == 0, w(20 + (e + 1) / 2 - 1), 1'b0);
      case (e)
        1, 3:    begin total++; if (dout !== 15'h5294) $display("FAIL post_rst e=%0d got %h exp 5294", e, dout); else passed++; end
        2, 4:    begin total++; if (dout !== 15'h6B5A) $display("FAIL post_rst e=%0d got %h exp 6B5A", e, dout); else passed++; end
        5:       begin total++; if ({running, dout_first, dout} !== {2'b11, 15'h1014}) $display("FAIL post_rst_first e=%0d got run=%b first=%b %h exp 1 1 1014", e, running, dout_first, dout); else passed++; end
        default: begin total++; if ({dout_first, dout} !== {1'b0, 15'h0114}) $display("FAIL post_rst_second e=%0d got first=%b %h exp 0 0114", e, dout_first, dout); else passed++; end
      endcase
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_underflow_restart();
    test_clr_alone();
    test_overflow();
    test_clr_vs_set();
    test_drain();
    test_reset_midword();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
